// File: rtl/pick_motion_ctrl.sv
// pick_motion_ctrl: turns held HID keycodes into frame-rate lock pick motion and settle status.
// Ports: Clk/Reset (async, active-high); frame_tick gates all motion; keycode W/S/D/A = up/down/insert/retract;
// level_active/level_done come from the level logic; pickY/pickLRx are the pick position; openner is 0
// only when the pick is inserted and motionless long enough (or locked); pick_state is the FSM state.
// Optional: define PICK_ACCEL_EN to double the Y step after 16 consecutive ticks of the same W/S key.
module pick_motion_ctrl #(
  parameter int Y_MIN        = 32,
  parameter int Y_MAX        = 479,
  parameter int X_HOME       = 620,
  parameter int X_INSERT     = 480,
  parameter int Y_STEP       = 2,
  parameter int X_STEP       = 4,
  parameter int SETTLE_TICKS = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       level_active,
  input  logic       level_done,
  output logic [9:0] pickY,
  output logic [9:0] pickLRx,
  output logic       openner,
  output logic [2:0] pick_state
);
  typedef enum logic [2:0] {
    HOME       = 3'd0,
    INSERTING  = 3'd1,
    INSERTED   = 3'd2,
    RETRACTING = 3'd3,
    LOCKED     = 3'd4
  } state_t;
  localparam int CW = $clog2(SETTLE_TICKS + 1);
  localparam logic [10:0] YMIN  = 11'(Y_MIN);
  localparam logic [10:0] YMAX  = 11'(Y_MAX);
  localparam logic [10:0] XHOME = 11'(X_HOME);
  localparam logic [10:0] XINS  = 11'(X_INSERT);
  localparam logic [10:0] XSTEP = 11'(X_STEP);
  localparam logic [10:0] YSTEP = 11'(Y_STEP);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_TICKS);
  state_t st_q, st_d, ins_st, ret_st;
  logic [9:0] y_q, y_d, x_q, x_d, y_mv, x_in, x_out;
  logic [CW-1:0] cnt_q, cnt_d;
  logic open_q, open_d;
  logic key_w, key_s, key_d, key_a;
  logic [10:0] ystep, ye, xe;
  assign key_w = keycode == 8'h1A;
  assign key_s = keycode == 8'h16;
  assign key_d = keycode == 8'h07;
  assign key_a = keycode == 8'h04;
`ifdef PICK_ACCEL_EN
  localparam logic [10:0] YSTEP2 = 11'(2 * Y_STEP);
  logic [4:0] hold_q, hold_d;
  logic last_s_q, last_s_d;
  assign ystep = (hold_q >= 5'd16) ? YSTEP2 : YSTEP;
  // hold_q counts consecutive ticks of the same vertical key; last_s_q remembers which one
  always_comb begin
    hold_d = hold_q;
    last_s_d = last_s_q;
    if (frame_tick) begin
      hold_d = !(key_w || key_s) ? 5'd0 :
               (hold_q != 5'd0 && last_s_q == key_s) ? ((hold_q == 5'd16) ? hold_q : hold_q + 5'd1) : 5'd1;
      last_s_d = (key_w || key_s) ? key_s : last_s_q;
    end
  end
`else
  assign ystep = YSTEP;
`endif
  // Y and X arithmetic in 11 bits so neither end can wrap before clamping
  assign ye = {1'b0, y_q};
  assign xe = {1'b0, x_q};
  assign y_mv = key_w ? ((ye < YMIN + ystep) ? 10'(YMIN) : 10'(ye - ystep)) :
                key_s ? ((ye + ystep > YMAX) ? 10'(YMAX) : 10'(ye + ystep)) : y_q;
  assign x_in  = (xe <= XINS + XSTEP) ? 10'(XINS) : 10'(xe - XSTEP);
  assign x_out = (xe + XSTEP >= XHOME) ? 10'(XHOME) : 10'(xe + XSTEP);
  assign ins_st = (x_in == 10'(XINS)) ? INSERTED : INSERTING;
  assign ret_st = (x_out == 10'(XHOME)) ? HOME : RETRACTING;
  // Direction changes take their first X step on the same tick that changes state
  always_comb begin
    st_d = st_q;
    y_d = y_q;
    x_d = x_q;
    cnt_d = cnt_q;
    if (st_q != HOME && !level_active) begin
      st_d = HOME;
      x_d = 10'(XHOME);
      cnt_d = '0;
    end else if (st_q == INSERTED && !open_q && level_done) begin
      st_d = LOCKED;
    end else if (frame_tick) begin
      case (st_q)
        HOME: begin
          st_d = (key_d && level_active) ? ins_st : HOME;
          x_d = (key_d && level_active) ? x_in : x_q;
          y_d = (key_d && level_active) ? y_q : y_mv;
        end
        INSERTING: begin
          st_d = key_a ? ret_st : ins_st;
          x_d = key_a ? x_out : x_in;
        end
        INSERTED: begin
          st_d = key_a ? ret_st : INSERTED;
          x_d = key_a ? x_out : x_q;
          y_d = key_a ? y_q : y_mv;
          cnt_d = (key_a || y_mv != y_q) ? '0 : (cnt_q == SETTLE) ? cnt_q : cnt_q + CW'(1);
        end
        RETRACTING: begin
          st_d = key_d ? ins_st : ret_st;
          x_d = key_d ? x_in : x_out;
        end
        default: ;
      endcase
    end
    open_d = !((st_d == INSERTED && cnt_d == SETTLE) || st_d == LOCKED);
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q <= HOME;
      y_q <= 10'(YMIN);
      x_q <= 10'(XHOME);
      cnt_q <= '0;
      open_q <= 1'b1;
`ifdef PICK_ACCEL_EN
      hold_q <= 5'd0;
      last_s_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      y_q <= y_d;
      x_q <= x_d;
      cnt_q <= cnt_d;
      open_q <= open_d;
`ifdef PICK_ACCEL_EN
      hold_q <= hold_d;
      last_s_q <= last_s_d;
`endif
    end
  end
  assign pickY = y_q;
  assign pickLRx = x_q;
  assign openner = open_q;
  assign pick_state = st_q;
endmodule

// File: tb/tb_pick_motion_ctrl.sv
// tb_pick_motion_ctrl: random and directed stimulus against a behavioural pick motion model.
module tb_pick_motion_ctrl;
  localparam int Y_MIN = 32, Y_MAX = 479, X_HOME = 620, X_INSERT = 480;
  localparam int Y_STEP = 2, X_STEP = 4, SETTLE = 4;
  localparam logic [7:0] KW = 8'h1A, KS = 8'h16, KD = 8'h07, KA = 8'h04;
`ifdef PICK_ACCEL_EN
  localparam int ACC_Y = 80;
`else
  localparam int ACC_Y = 72;
`endif
  logic Clk = 0, Reset, frame_tick, level_active, level_done;
  logic [7:0] keycode;
  logic [9:0] pickY, pickLRx;
  logic openner;
  logic [2:0] pick_state;
  int total = 0, bad = 0;
  bit chk_en = 0;
  pick_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .level_active(level_active), .level_done(level_done),
    .pickY(pickY), .pickLRx(pickLRx), .openner(openner), .pick_state(pick_state)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    int st, y, x, cnt, open, hold, last_s;
  } model_t;
  model_t m;
  function automatic int imin(int a, int b); return a < b ? a : b; endfunction
  function automatic int imax(int a, int b); return a > b ? a : b; endfunction
  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.y = Y_MIN; r.x = X_HOME; r.cnt = 0; r.open = 1; r.hold = 0; r.last_s = 0;
    return r;
  endfunction
  // state numbers: 0 home, 1 inserting, 2 inserted, 3 retracting, 4 locked
  function automatic model_t nxt(model_t c, logic ft, logic [7:0] k, logic la, logic ld);
    model_t n = c;
    bit w = (k == KW), s = (k == KS), d = (k == KD), a = (k == KA);
    int dir, step;
    step = Y_STEP;
`ifdef PICK_ACCEL_EN
    if (c.hold >= 16) step = 2 * Y_STEP;
`endif
    if (ft) begin
      n.hold = (w || s) ? ((c.hold > 0 && c.last_s == int'(s)) ? imin(c.hold + 1, 16) : 1) : 0;
      if (w || s) n.last_s = int'(s);
    end
    if (c.st != 0 && !la) begin
      n.st = 0; n.x = X_HOME; n.cnt = 0;
    end else if (c.st == 2 && c.open == 0 && ld) begin
      n.st = 4;
    end else if (ft && c.st != 4) begin
      case (c.st)
        0: dir = (d && la) ? -1 : 0;
        1: dir = a ? 1 : -1;
        2: dir = a ? 1 : 0;
        default: dir = d ? -1 : 1;
      endcase
      if (dir < 0) begin
        n.x = imax(c.x - X_STEP, X_INSERT); n.st = (n.x == X_INSERT) ? 2 : 1;
      end else if (dir > 0) begin
        n.x = imin(c.x + X_STEP, X_HOME); n.st = (n.x == X_HOME) ? 0 : 3;
      end else if (c.st == 0 || c.st == 2) begin
        n.y = w ? imax(c.y - step, Y_MIN) : s ? imin(c.y + step, Y_MAX) : c.y;
      end
      n.cnt = (c.st == 2 && n.st == 2) ? ((n.y != c.y) ? 0 : imin(c.cnt + 1, SETTLE)) : 0;
    end
    n.open = ((n.st == 2 && n.cnt == SETTLE) || n.st == 4) ? 0 : 1;
    return n;
  endfunction
  always @(posedge Clk or posedge Reset)
    if (Reset) m <= model_reset();
    else m <= nxt(m, frame_tick, keycode, level_active, level_done);
  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      if (bad < 30) $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      bad++;
    end
  endtask
  always @(negedge Clk)
    if (chk_en) begin
      cmp("model_pickY", int'(pickY), m.y);
      cmp("model_pickLRx", int'(pickLRx), m.x);
      cmp("model_openner", int'(openner), m.open);
      cmp("model_state", int'(pick_state), m.st);
    end
  task automatic tick(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      keycode = k; frame_tick = 1;
      @(posedge Clk); #1;
      frame_tick = 0;
      @(posedge Clk); #1;
    end
  endtask
  task automatic tap(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      tick(k, 1);
      tick(8'h00, 1);
    end
  endtask
  initial begin
    Reset = 1; frame_tick = 0; keycode = 0; level_active = 0; level_done = 0;
    @(posedge Clk); #1 chk_en = 1;
    @(posedge Clk); #1 Reset = 0;
    cmp("rst_y", int'(pickY), 32);
    cmp("rst_x", int'(pickLRx), 620);
    cmp("rst_open", int'(openner), 1);
    cmp("rst_state", int'(pick_state), 0);
    tick(KS, 20);
    cmp("hold_s20_y", int'(pickY), ACC_Y);
    level_active = 1;
    tick(KD, 15);
    cmp("mid_ins_x", int'(pickLRx), 560);
    cmp("mid_ins_state", int'(pick_state), 1);
    #3 Reset = 1;
    #1 cmp("async_rst_x", int'(pickLRx), 620);
    @(posedge Clk); #1;
    cmp("rst2_y", int'(pickY), 32);
    cmp("rst2_x", int'(pickLRx), 620);
    cmp("rst2_open", int'(openner), 1);
    cmp("rst2_state", int'(pick_state), 0);
    Reset = 0;
    tap(KS, 223);
    cmp("y_478", int'(pickY), 478);
    tick(KS, 1);
    cmp("y_sat_max", int'(pickY), 479);
    tap(KW, 223);
    cmp("y_33", int'(pickY), 33);
    tap(KW, 1);
    cmp("y_sat_min", int'(pickY), 32);
    tick(KD, 34);
    cmp("ins34_x", int'(pickLRx), 484);
    cmp("ins34_state", int'(pick_state), 1);
    tick(KD, 1);
    cmp("ins35_x", int'(pickLRx), 480);
    cmp("ins35_state", int'(pick_state), 2);
    cmp("ins35_open", int'(openner), 1);
    tick(KS, 10);
    cmp("s10_y", int'(pickY), 52);
    cmp("s10_open", int'(openner), 1);
    tick(8'h00, 3);
    cmp("settle3_open", int'(openner), 1);
    tick(8'h00, 1);
    cmp("settle4_open", int'(openner), 0);
    keycode = KW; frame_tick = 1; level_done = 1;
    @(posedge Clk); #1;
    cmp("lock_state", int'(pick_state), 4);
    cmp("lock_y", int'(pickY), 52);
    cmp("lock_open", int'(openner), 0);
    frame_tick = 0; level_done = 0; keycode = 0; level_active = 0;
    @(posedge Clk); #1;
    cmp("unlock_state", int'(pick_state), 0);
    cmp("unlock_x", int'(pickLRx), 620);
    cmp("unlock_y", int'(pickY), 52);
    cmp("unlock_open", int'(openner), 1);
    level_active = 1;
    for (int i = 0; i < 6000; i++) begin
      int r;
      Reset = ($urandom_range(0, 799) == 0);
      frame_tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, 9);
        keycode = r < 3 ? 8'h00 : r == 3 ? KW : r == 4 ? KS : r < 7 ? KD : r == 7 ? KA : 8'($urandom);
      end
      level_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 249) == 0) level_active = !level_active;
      @(posedge Clk); #1;
    end
    Reset = 0; frame_tick = 0;
    repeat (2) @(posedge Clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
